// File: rtl/br_target_pred.sv
`default_nettype none
// ============================================================================
//  Module      : br_target_pred
//  Description : Direct-mapped branch target buffer with a 2-bit saturating
//                counter per entry. Fetch-side lookup is purely combinational;
//                the execute stage trains entries through the update port.
//  Revision    : 1.0  initial release
// ============================================================================
module br_target_pred #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 3,
    parameter int ALLOC_CNT  = 2,
    parameter int RST_CNT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Flush_i,
    input  logic              Update_i,
    input  logic              BranchTaken_i,
    input  logic [ADDR_W-1:0] WriteAddr_i,
    input  logic [ADDR_W-1:0] WriteTarget_i,
    input  logic [ADDR_W-1:0] ReadAddr_i,
    output logic [ADDR_W-1:0] ReadTarget_o,
    output logic              Hit_o
);

    localparam int         NUM_ENTRY   = 1 << INDEX_BITS;
    localparam int         TAG_W       = ADDR_W - INDEX_BITS - 2;
    localparam logic [1:0] c_alloc_cnt = 2'(ALLOC_CNT);
    localparam logic [1:0] c_rst_cnt   = 2'(RST_CNT);

    // Entry storage, kept in flops so every entry resets cleanly.
    logic [NUM_ENTRY-1:0]             r_valid;
    logic [NUM_ENTRY-1:0][1:0]        r_cnt;
    logic [NUM_ENTRY-1:0][TAG_W-1:0]  r_tag;
    logic [NUM_ENTRY-1:0][ADDR_W-1:0] r_target;

    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [TAG_W-1:0]      w_rd_tag;
    logic                  w_rd_match;
    logic [INDEX_BITS-1:0] w_wr_idx;
    logic [TAG_W-1:0]      w_wr_tag;
    logic                  w_wr_match;
    logic [1:0]            w_cnt_cur;
    logic [1:0]            w_cnt_next;
    logic                  w_unused_addr_lsbs;

    // Byte offset within the instruction word plays no part in indexing.
    assign w_unused_addr_lsbs = ^{ReadAddr_i[1:0], WriteAddr_i[1:0]};

    assign w_rd_idx = ReadAddr_i[INDEX_BITS+1:2];
    assign w_rd_tag = ReadAddr_i[ADDR_W-1:INDEX_BITS+2];
    assign w_wr_idx = WriteAddr_i[INDEX_BITS+1:2];
    assign w_wr_tag = WriteAddr_i[ADDR_W-1:INDEX_BITS+2];

    // Fetch lookup: the target is exposed on any tag match, the redirect
    // only when the counter is in one of the two taken states.
    always_comb begin
        w_rd_match   = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
        Hit_o        = w_rd_match && r_cnt[w_rd_idx][1];
        ReadTarget_o = w_rd_match ? r_target[w_rd_idx] : '0;
    end

    // Training side: match detection and the saturating counter step.
    always_comb begin
        w_wr_match = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
        w_cnt_cur  = r_cnt[w_wr_idx];
        w_cnt_next = w_cnt_cur;
        if (BranchTaken_i) begin
            if (w_cnt_cur != 2'd3) begin
                w_cnt_next = w_cnt_cur + 2'd1;
            end
        end else begin
            if (w_cnt_cur != 2'd0) begin
                w_cnt_next = w_cnt_cur - 2'd1;
            end
        end
    end

    // State update with priority reset > flush > update. Flush leaves tags
    // and targets stale; they are unreachable once valid is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid  <= '0;
            r_cnt    <= {NUM_ENTRY{c_rst_cnt}};
            r_tag    <= '0;
            r_target <= '0;
        end else if (Flush_i) begin
            r_valid  <= '0;
            r_cnt    <= {NUM_ENTRY{c_rst_cnt}};
        end else if (Update_i) begin
            if (w_wr_match) begin
                r_cnt[w_wr_idx] <= w_cnt_next;
                if (BranchTaken_i) begin
                    r_target[w_wr_idx] <= WriteTarget_i;
                end
            end else if (BranchTaken_i) begin
                // Not-taken misses are never allocated.
                r_valid[w_wr_idx]  <= 1'b1;
                r_tag[w_wr_idx]    <= w_wr_tag;
                r_target[w_wr_idx] <= WriteTarget_i;
                r_cnt[w_wr_idx]    <= c_alloc_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_br_target_pred.sv
`default_nettype none
// ============================================================================
//  Module      : tb_br_target_pred
//  Description : Bench for br_target_pred. Two instances (INDEX_BITS 3 and 5)
//                share one stimulus stream and are compared every cycle with
//                a table-based reference model of the buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_br_target_pred;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        update;
    logic        taken;
    logic [31:0] waddr;
    logic [31:0] wtarget;
    logic [31:0] raddr;
    logic [31:0] rtarget_s;
    logic        hit_s;
    logic [31:0] rtarget_l;
    logic        hit_l;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: entry k=0 for the 8-entry instance, k=1 for 32-entry.
    bit          m_valid [2][32];
    int unsigned m_tag   [2][32];
    int unsigned m_tgt   [2][32];
    int          m_cnt   [2][32];

    always #5 clk = ~clk;

    br_target_pred #(.ADDR_W(32), .INDEX_BITS(3)) dut_small (
        .clk(clk), .rst(rst), .Flush_i(flush), .Update_i(update),
        .BranchTaken_i(taken), .WriteAddr_i(waddr), .WriteTarget_i(wtarget),
        .ReadAddr_i(raddr), .ReadTarget_o(rtarget_s), .Hit_o(hit_s)
    );

    br_target_pred #(.ADDR_W(32), .INDEX_BITS(5)) dut_large (
        .clk(clk), .rst(rst), .Flush_i(flush), .Update_i(update),
        .BranchTaken_i(taken), .WriteAddr_i(waddr), .WriteTarget_i(wtarget),
        .ReadAddr_i(raddr), .ReadTarget_o(rtarget_l), .Hit_o(hit_l)
    );

    function automatic int ibits(input int k);
        return (k == 0) ? 3 : 5;
    endfunction

    function automatic int idx_of(input int k, input int unsigned a);
        return int'((a / 4) % (32'd1 << ibits(k)));
    endfunction

    function automatic int unsigned tag_of(input int k, input int unsigned a);
        return a >> (ibits(k) + 2);
    endfunction

    task automatic model_reset(input bit full);
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 32; e++) begin
                m_valid[k][e] = 1'b0;
                m_cnt[k][e]   = 1;
                if (full) begin
                    m_tag[k][e] = 0;
                    m_tgt[k][e] = 0;
                end
            end
        end
    endtask

    task automatic model_update(input bit tk, input int unsigned wa, input int unsigned wt);
        for (int k = 0; k < 2; k++) begin
            int i;
            i = idx_of(k, wa);
            if (m_valid[k][i] && m_tag[k][i] == tag_of(k, wa)) begin
                if (tk) begin
                    m_cnt[k][i] = (m_cnt[k][i] < 3) ? m_cnt[k][i] + 1 : 3;
                    m_tgt[k][i] = wt;
                end else begin
                    m_cnt[k][i] = (m_cnt[k][i] > 0) ? m_cnt[k][i] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[k][i] = 1'b1;
                m_tag[k][i]   = tag_of(k, wa);
                m_tgt[k][i]   = wt;
                m_cnt[k][i]   = 2;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs applied at the falling edge, outputs compared against
    // the model's pre-edge prediction, then the model takes the rising edge.
    task automatic cyc(input string name, input bit rn, input bit fl, input bit up,
                       input bit tk, input logic [31:0] wa, input logic [31:0] wt,
                       input logic [31:0] ra);
        rst = rn; flush = fl; update = up; taken = tk;
        waddr = wa; wtarget = wt; raddr = ra;
        #2;
        for (int k = 0; k < 2; k++) begin
            int          i;
            bit          match;
            logic [31:0] exp_tgt;
            logic [31:0] exp_hit;
            i       = idx_of(k, ra);
            match   = m_valid[k][i] && (m_tag[k][i] == tag_of(k, ra));
            exp_hit = {31'd0, match && (m_cnt[k][i] >= 2)};
            exp_tgt = match ? m_tgt[k][i] : 32'd0;
            if (k == 0) begin
                check({name, "/hit8"}, {31'd0, hit_s}, exp_hit);
                check({name, "/tgt8"}, rtarget_s, exp_tgt);
            end else begin
                check({name, "/hit32"}, {31'd0, hit_l}, exp_hit);
                check({name, "/tgt32"}, rtarget_l, exp_tgt);
            end
        end
        @(posedge clk);
        if (!rn)      model_reset(1'b1);
        else if (fl)  model_reset(1'b0);
        else if (up)  model_update(tk, wa, wt);
        @(negedge clk);
    endtask

    // Plain update helper and plain read helper.
    task automatic upd(input string name, input bit tk, input logic [31:0] wa,
                       input logic [31:0] wt, input logic [31:0] ra);
        cyc(name, 1'b1, 1'b0, 1'b1, tk, wa, wt, ra);
    endtask

    task automatic rd(input string name, input logic [31:0] ra);
        cyc(name, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ra);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; update = 1'b0; taken = 1'b0;
        waddr = '0; wtarget = '0; raddr = 32'h100;
        model_reset(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset and flush leave everything missing.
        cyc("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
        rd ("post_rst", 32'h100);
        cyc("flush", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
        rd ("post_flush", 32'h100);

        // Allocation, then explicit spec values after allocation.
        upd("alloc", 1'b1, 32'h100, 32'h200, 32'h100);
        rd ("alloc_rd", 32'h100);
        check("alloc_hit_abs", {31'd0, hit_s}, 32'd1);
        check("alloc_tgt_abs", rtarget_s, 32'h200);

        // Counter walk: 1 not-taken, 4 taken, 2 not-taken, 5 not-taken.
        upd("nt1", 1'b0, 32'h100, 32'h999, 32'h100);
        rd ("nt1_rd", 32'h100);
        check("nt1_hit_abs", {31'd0, hit_s}, 32'd0);
        check("nt1_tgt_abs", rtarget_s, 32'h200);
        repeat (4) upd("tk_sat", 1'b1, 32'h100, 32'h200, 32'h100);
        repeat (2) upd("nt_dn", 1'b0, 32'h100, 32'h0, 32'h100);
        rd ("cnt1_rd", 32'h100);
        check("cnt1_hit_abs", {31'd0, hit_s}, 32'd0);
        repeat (5) upd("nt_floor", 1'b0, 32'h100, 32'h0, 32'h100);
        upd("from0", 1'b1, 32'h100, 32'h204, 32'h100);
        rd ("from0_rd", 32'h100);
        check("from0_hit_abs", {31'd0, hit_s}, 32'd0);

        // Not-taken miss never allocates; aliasing evicts.
        upd("nt_empty", 1'b0, 32'h104, 32'h500, 32'h104);
        rd ("nt_empty_rd", 32'h104);
        upd("alias_a", 1'b1, 32'h100, 32'h210, 32'h120);
        upd("alias_b", 1'b1, 32'h120, 32'h220, 32'h100);
        rd ("alias_rd_a", 32'h100);
        check("alias_evict_abs", rtarget_s, 32'h0);
        rd ("alias_rd_b", 32'h123);

        // Same-cycle read/write: no bypass; flush beats update.
        upd("rw_same", 1'b1, 32'h140, 32'h300, 32'h140);
        rd ("rw_next", 32'h140);
        cyc("flush_upd", 1'b1, 1'b1, 1'b1, 1'b1, 32'h148, 32'h400, 32'h148);
        rd ("flush_upd_rd", 32'h148);

        // Train several entries, then a mid-stream reset drops them all.
        for (int i = 0; i < 8; i++) upd("train", 1'b1, 32'h1000 + 32'(4 * i), 32'h8000 + 32'(i), 32'h1000);
        cyc("rst_upd", 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h1, 32'h1004);
        for (int i = 0; i < 8; i++) rd("post_rst_rd", 32'h1000 + 32'(4 * i));

        // Randomized traffic on a small address pool to force hits and aliases.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] wa;
            logic [31:0] ra;
            bit          rn;
            bit          fl;
            wa = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? wa :
                 ((32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2));
            rn = ($urandom_range(0, 99) != 0);
            fl = ($urandom_range(0, 49) == 0);
            cyc("rand", rn, fl, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
                wa, $urandom, ra);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
